// File: rtl/pixel_pack4.sv
// pixel_pack4: packs a stream of PIX_W-bit pixels into little-endian 4-pixel words
// with valid/ready on both sides and a flush path for partial words.
// Optional feature: define PACK_WORD_COUNT_EN to add the word_count port/counter.
module pixel_pack4 #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   pixel_in,
  input  logic               pixel_valid,
  output logic               pixel_ready,
  input  logic               flush_req,
  output logic               flush_ack,
  output logic [4*PIX_W-1:0] word_out,
  output logic [3:0]         byte_en,
  output logic               word_valid,
  input  logic               word_ready,
`ifdef PACK_WORD_COUNT_EN
  output logic [1:0]         fill_cnt,
  output logic [CNT_W-1:0]   word_count
`else
  output logic [1:0]         fill_cnt
`endif
);

  localparam int unsigned WORD_W = 4 * PIX_W;
  localparam int unsigned ACC_W  = 3 * PIX_W;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_nx;
  logic [1:0]        fill_nx;
  logic [WORD_W-1:0] word_nx;
  logic [3:0]        be_nx;
  logic              valid_nx;
  logic              slot_free;
  logic              pix_take;

  // Handshake decode and next-state: pixel packing first, then flush on the post-accept fill.
  always_comb begin
    slot_free   = ~word_valid | word_ready;
    pixel_ready = (fill_cnt != 2'd3) | slot_free;
    flush_ack   = flush_req & slot_free;
    pix_take    = pixel_valid & pixel_ready;
    acc_nx      = acc;
    fill_nx     = fill_cnt;
    word_nx     = word_out;
    be_nx       = byte_en;
    valid_nx    = word_valid & ~word_ready;

    if (pix_take) begin
      if (fill_cnt == 2'd3) begin
        word_nx  = {pixel_in, acc};
        be_nx    = 4'hF;
        valid_nx = 1'b1;
        acc_nx   = '0;
        fill_nx  = 2'd0;
      end else begin
        case (fill_cnt)
          2'd0:    acc_nx[PIX_W-1:0]         = pixel_in;
          2'd1:    acc_nx[2*PIX_W-1:PIX_W]   = pixel_in;
          default: acc_nx[3*PIX_W-1:2*PIX_W] = pixel_in;
        endcase
        fill_nx = fill_cnt + 2'd1;
      end
    end

    // Lanes at or above the fill level are already zero because acc clears on every emit.
    if (flush_ack && (fill_nx != 2'd0)) begin
      word_nx  = {{PIX_W{1'b0}}, acc_nx};
      case (fill_nx)
        2'd1:    be_nx = 4'b0001;
        2'd2:    be_nx = 4'b0011;
        default: be_nx = 4'b0111;
      endcase
      valid_nx = 1'b1;
      acc_nx   = '0;
      fill_nx  = 2'd0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      fill_cnt   <= 2'd0;
      word_out   <= '0;
      byte_en    <= 4'h0;
      word_valid <= 1'b0;
    end else begin
      acc        <= acc_nx;
      fill_cnt   <= fill_nx;
      word_out   <= word_nx;
      byte_en    <= be_nx;
      word_valid <= valid_nx;
    end
  end

`ifdef PACK_WORD_COUNT_EN
  // Count every accepted output word, full or partial; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_count <= '0;
    end else if (word_valid && word_ready) begin
      word_count <= word_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pixel_pack4.sv
// Randomized and directed bench for pixel_pack4 against a queue-based pixel/word model.
module tb_pixel_pack4;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned CNT_W = 16;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [PIX_W-1:0]   pixel_in;
  logic               pixel_valid;
  logic               pixel_ready;
  logic               flush_req;
  logic               flush_ack;
  logic [4*PIX_W-1:0] word_out;
  logic [3:0]         byte_en;
  logic               word_valid;
  logic               word_ready;
  logic [1:0]         fill_cnt;
`ifdef PACK_WORD_COUNT_EN
  logic [CNT_W-1:0]   word_count;
`endif

  always #5 clk = ~clk;

  pixel_pack4 #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .flush_req   (flush_req),
    .flush_ack   (flush_ack),
    .word_out    (word_out),
    .byte_en     (byte_en),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
`ifdef PACK_WORD_COUNT_EN
    .fill_cnt    (fill_cnt),
    .word_count  (word_count)
`else
    .fill_cnt    (fill_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Single comparison point: counts, reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixels waiting to form a word, plus the single output slot.
  byte unsigned pend[$];
  bit           m_v;
  logic [31:0]  m_word;
  logic [3:0]   m_be;
  int unsigned  m_cnt;

  bit           chk_en;
  bit           last_acc;
  bit           last_fa;
  logic [31:0]  got_words[$];

  function automatic logic [31:0] pack(input byte unsigned q[$]);
    logic [31:0] w = 32'h0;
    foreach (q[k]) w = w + (32'(q[k]) << (8 * k));
    return w;
  endfunction

  // One clock cycle: drive at negedge, check just after, update model after posedge.
  task automatic step(input bit pv, input logic [7:0] pin, input bit fr, input bit wr, input bit rs);
    bit exp_pr;
    bit exp_fa;
    @(negedge clk);
    pixel_valid = pv;
    pixel_in    = pin;
    flush_req   = fr;
    word_ready  = wr;
    rst_n       = ~rs;
    #1;
    exp_pr = (pend.size() != 3) || !m_v || wr;
    exp_fa = fr && (!m_v || wr);
    if (chk_en) begin
      check("pixel_ready", 32'(pixel_ready), 32'(exp_pr));
      check("flush_ack",   32'(flush_ack),   32'(exp_fa));
      check("word_valid",  32'(word_valid),  32'(m_v));
      check("fill_cnt",    32'(fill_cnt),    32'(pend.size()));
      if (m_v) begin
        check("word_out", word_out, m_word);
        check("byte_en",  32'(byte_en), 32'(m_be));
      end
`ifdef PACK_WORD_COUNT_EN
      check("word_count", 32'(word_count), m_cnt);
`endif
    end
    if (word_valid && wr && !rs) got_words.push_back(word_out);
    last_acc = pv && exp_pr;
    last_fa  = exp_fa;
    @(posedge clk);
    #1;
    if (rs) begin
      pend.delete();
      m_v = 1'b0; m_word = '0; m_be = '0; m_cnt = 0;
    end else begin
      if (m_v && wr) begin
        m_v   = 1'b0;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      if (last_acc) begin
        pend.push_back(pin);
        if (pend.size() == 4) begin
          m_word = pack(pend); m_be = 4'hF; m_v = 1'b1;
          pend.delete();
        end
      end
      if (exp_fa && pend.size() > 0) begin
        m_word = pack(pend);
        m_be   = 4'((1 << pend.size()) - 1);
        m_v    = 1'b1;
        pend.delete();
      end
    end
  endtask

  task automatic do_reset();
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
  endtask

  logic [7:0] pix8[8];

  initial begin
    bit         fr_hold;
    bit         pv_hold;
    logic [7:0] pv_data;

    pixel_valid = 0; pixel_in = '0; flush_req = 0; word_ready = 0; rst_n = 0;
    chk_en = 0;
    pend.delete(); m_v = 0; m_word = '0; m_be = '0; m_cnt = 0;
    do_reset();
    chk_en = 1;

    // Reset state
    check("rst_word_out", word_out, 32'h0);
    check("rst_byte_en", 32'(byte_en), 32'h0);
    check("rst_word_valid", 32'(word_valid), 32'h0);
    check("rst_fill_cnt", 32'(fill_cnt), 32'h0);

    // Four back-to-back pixels form one word, valid the cycle after the 4th
    step(1, 8'h11, 0, 1, 0);
    check("rst_pixel_ready", 32'(pixel_ready), 32'h1);
    step(1, 8'h22, 0, 1, 0);
    step(1, 8'h33, 0, 1, 0);
    step(1, 8'h44, 0, 1, 0);
    check("t1_word", word_out, 32'h44332211);
    check("t1_be", 32'(byte_en), 32'hF);
    check("t1_valid", 32'(word_valid), 32'h1);
    step(0, 8'h00, 0, 1, 0);

    // Backpressure: 8 pixels, word_ready low until cycle 10
    do_reset();
    got_words.delete();
    for (int i = 0; i < 8; i++) pix8[i] = 8'(i + 1);
    begin
      int idx = 0;
      for (int c = 0; c < 24; c++) begin
        step(idx < 8, (idx < 8) ? pix8[idx] : 8'h00, 0, c >= 10, 0);
        if (last_acc) idx++;
      end
      check("t2_all_taken", 32'(idx), 32'd8);
    end
    check("t2_nwords", 32'(got_words.size()), 32'd2);
    if (got_words.size() == 2) begin
      check("t2_word0", got_words[0], 32'h04030201);
      check("t2_word1", got_words[1], 32'h08070605);
    end

    // Flush of a two-pixel partial
    step(1, 8'hAA, 0, 1, 0);
    step(1, 8'hBB, 0, 1, 0);
    step(0, 8'h00, 1, 1, 0);
    check("t3_ack", 32'(last_fa), 32'h1);
    check("t3_word", word_out, 32'h0000BBAA);
    check("t3_be", 32'(byte_en), 32'h3);
    check("t3_fill", 32'(fill_cnt), 32'h0);
    step(0, 8'h00, 0, 1, 0);

    // Fourth pixel with flush in the same cycle: one full word, no empty extra
    step(1, 8'hC1, 0, 1, 0);
    step(1, 8'hC2, 0, 1, 0);
    step(1, 8'hC3, 0, 1, 0);
    step(1, 8'hC4, 1, 1, 0);
    check("t4_word", word_out, 32'hC4C3C2C1);
    check("t4_be", 32'(byte_en), 32'hF);
    step(0, 8'h00, 0, 1, 0);
    check("t4_no_extra", 32'(word_valid), 32'h0);

    // Empty flush: acks, emits nothing
    step(0, 8'h00, 1, 1, 0);
    check("t5_ack", 32'(last_fa), 32'h1);
    check("t5_no_word", 32'(word_valid), 32'h0);

    // Reset mid-group with a pending word, then a clean word
    for (int i = 0; i < 4; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
    step(1, 8'h61, 0, 0, 0);
    step(1, 8'h62, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    check("t6_valid", 32'(word_valid), 32'h0);
    check("t6_fill", 32'(fill_cnt), 32'h0);
    step(1, 8'h71, 0, 1, 0);
    step(1, 8'h72, 0, 1, 0);
    step(1, 8'h73, 0, 1, 0);
    step(1, 8'h74, 0, 1, 0);
    check("t6_word", word_out, 32'h74737271);
    step(0, 8'h00, 0, 1, 0);

`ifdef PACK_WORD_COUNT_EN
    // 3 full words plus one flushed partial
    do_reset();
    for (int i = 0; i < 14; i++) step(1, 8'(i), 0, 1, 0);
    step(0, 8'h00, 1, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    step(0, 8'h00, 0, 1, 0);
    check("t7_word_count", 32'(word_count), 32'd4);
`endif

    // Randomized traffic with held requests
    fr_hold = 0; pv_hold = 0; pv_data = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!pv_hold && ($urandom_range(0, 3) != 0)) begin
        pv_hold = 1; pv_data = 8'($urandom);
      end
      if (!fr_hold && ($urandom_range(0, 11) == 0)) fr_hold = 1;
      step(pv_hold, pv_data, fr_hold, $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
      if (last_acc) pv_hold = 0;
      if (last_fa) fr_hold = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
